// File: rtl/layer1_pixel_streamer.sv
`default_nettype none
// ============================================================================
// layer1_pixel_streamer: raster replay of the image RAM through a skid buffer;
// optional per-row read gaps with PIXEL_STREAMER_ROW_GAP_EN.   Revision 1.0
// ============================================================================
module layer1_pixel_streamer #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  out_ready_i,
  output logic                  pix_valid_o,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic [9:0]            pix_x_o,
  output logic [9:0]            pix_y_o,
  output logic                  frame_last_o
);

  localparam int                    c_NUM_PIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_NUM_PIX - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [9:0]            c_LAST_X    = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]            c_LAST_Y    = 10'(IMG_HEIGHT - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_FETCH = 2'd1;
`ifdef PIXEL_STREAMER_ROW_GAP_EN
  localparam logic [1:0] c_ST_GAP   = 2'd2;
`endif
  localparam logic [1:0] c_ST_DRAIN = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en_q;
  logic                  rvalid_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;

  logic w_accept;
  logic w_pop;
  logic w_out_free;
  logic w_shift;
  logic w_push;
  logic w_last_xfer;
  logic w_last_addr;
  logic w_credit_ok;
  logic w_issue;

  assign w_accept    = (state_q == c_ST_IDLE) && start_i && !done_q;
  assign w_pop       = out_valid_q && out_ready_i;
  assign w_out_free  = !out_valid_q || w_pop;
  assign w_shift     = w_out_free && (skid_cnt_q != 2'd0);
  assign w_push      = rvalid_q && !(w_out_free && (skid_cnt_q == 2'd0));
  assign w_last_xfer = w_pop && (x_q == c_LAST_X) && (y_q == c_LAST_Y);
  assign w_last_addr = (rd_cnt_q == c_LAST_ADDR);

  // The output register is the presentation stage; the 2-entry skid plus the
  // two RAM pipeline stages may never exceed 2, so a stall cannot lose data.
  assign w_credit_ok = (({1'b0, skid_cnt_d} + {2'b00, rd_en_q}) <= 3'd1);

`ifdef PIXEL_STREAMER_ROW_GAP_EN
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [9:0]         rd_col_q;
  logic [c_GAP_W-1:0] gap_cnt_q;
  logic               w_row_end;
  logic               w_gap_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_col_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (w_accept) begin
        rd_col_q <= (IMG_WIDTH == 1) ? 10'd0 : 10'd1;
      end else if (w_issue) begin
        rd_col_q <= (rd_col_q == c_LAST_X) ? 10'd0 : rd_col_q + 10'd1;
      end
      if (state_q == c_ST_GAP) begin
        gap_cnt_q <= gap_cnt_q + c_GAP_W'(1);
      end else begin
        gap_cnt_q <= '0;
      end
    end
  end

  assign w_row_end  = (rd_col_q == c_LAST_X) && !w_last_addr;
  assign w_gap_exit = (gap_cnt_q == c_GAP_W'(GAP_CYCLES - 1));
`else
  logic w_unused_gap;
  assign w_unused_gap = ^GAP_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_accept) begin
          state_d = (c_NUM_PIX == 1) ? c_ST_DRAIN : c_ST_FETCH;
        end
      end
      c_ST_FETCH: begin
        if (w_issue && w_last_addr) begin
          state_d = c_ST_DRAIN;
        end
`ifdef PIXEL_STREAMER_ROW_GAP_EN
        else if (w_issue && w_row_end) begin
          state_d = c_ST_GAP;
        end
`endif
      end
`ifdef PIXEL_STREAMER_ROW_GAP_EN
      c_ST_GAP: begin
        if (w_gap_exit) begin
          state_d = c_ST_FETCH;
        end
      end
`endif
      c_ST_DRAIN: begin
        if (w_last_xfer) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // The start edge itself issues address 0.
  always_comb begin
    w_issue = 1'b0;
    case (state_q)
      c_ST_IDLE:  w_issue = w_accept;
      c_ST_FETCH: w_issue = w_credit_ok;
      default:    w_issue = 1'b0;
    endcase
  end

  always_comb begin
    busy_d   = busy_q;
    done_d   = w_last_xfer;
    addr_d   = addr_q;
    rd_cnt_d = rd_cnt_q;
    if (w_accept) begin
      busy_d   = 1'b1;
      addr_d   = '0;
      rd_cnt_d = c_ADDR_ONE;
    end else if (w_issue) begin
      addr_d   = rd_cnt_q;
      rd_cnt_d = rd_cnt_q + c_ADDR_ONE;
    end
    if (w_last_xfer) begin
      busy_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (w_out_free) begin
      if (skid_cnt_q != 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = skid0_q;
      end else if (rvalid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_rdata_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    skid0_d    = w_shift ? skid1_q : skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q - {1'b0, w_shift};
    if (w_push) begin
      if (skid_cnt_d == 2'd0) begin
        skid0_d = mem_rdata_i;
      end else begin
        skid1_d = mem_rdata_i;
      end
      skid_cnt_d = skid_cnt_d + 2'd1;
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (w_accept) begin
      x_d = '0;
      y_d = '0;
    end else if (w_pop) begin
      if (x_q == c_LAST_X) begin
        x_d = '0;
        y_d = (y_q == c_LAST_Y) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      addr_q      <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid0_q     <= '0;
      skid1_q     <= '0;
      skid_cnt_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= w_issue;
      rvalid_q    <= rd_en_q;
      addr_q      <= addr_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      skid_cnt_q  <= skid_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign mem_rd_en_o  = rd_en_q;
  assign mem_addr_o   = addr_q;
  assign pix_valid_o  = out_valid_q;
  assign pix_data_o   = out_data_q;
  assign pix_x_o      = x_q;
  assign pix_y_o      = y_q;
  assign frame_last_o = out_valid_q && (x_q == c_LAST_X) && (y_q == c_LAST_Y);

endmodule
`default_nettype wire

// File: tb/tb_layer1_pixel_streamer.sv
`default_nettype none
// ============================================================================
// tb_layer1_pixel_streamer: directed bench with a transfer scoreboard.
// Revision 1.0
// ============================================================================
module tb_layer1_pixel_streamer;

  localparam int W   = 28;
  localparam int H   = 28;
  localparam int N   = W * H;
  localparam int GAP = 4;
`ifdef PIXEL_STREAMER_ROW_GAP_EN
  localparam int EXP_FRAME = N + 2 + (H - 1) * GAP;
`else
  localparam int EXP_FRAME = N + 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       out_ready;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_last;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         mon_k    = 0;
  int         n_done   = 0;
  logic [7:0] seed     = 8'h00;

  layer1_pixel_streamer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_WIDTH(8),
    .ADDR_WIDTH(10),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .mem_rd_en_o (mem_rd_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .out_ready_i (out_ready),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data),
    .pix_x_o     (pix_x),
    .pix_y_o     (pix_y),
    .frame_last_o(frame_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM holding a seeded ramp.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_addr[7:0] ^ seed;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every transfer must be the next pixel in raster order.
  initial begin
    logic        stall;
    logic [28:0] hold;
    logic [7:0]  exp_d;
    logic [9:0]  exp_x;
    logic [9:0]  exp_y;
    stall = 1'b0;
    hold  = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("credit", (int'(dut.skid_cnt_q) + int'(dut.rd_en_q) + int'(dut.rvalid_q)) <= 2, 1);
        if (stall && pix_valid)
          check("stall_hold", {pix_data, pix_x, pix_y, frame_last}, hold);
        if (pix_valid && out_ready) begin
          exp_d = 8'(mon_k) ^ seed;
          exp_x = 10'(mon_k % W);
          exp_y = 10'(mon_k / W);
          check("xfer_in_frame", mon_k < N, 1);
          check("xfer", {pix_data, pix_x, pix_y, frame_last},
                {exp_d, exp_x, exp_y, (mon_k == N - 1)});
          mon_k++;
        end
        stall = pix_valid && !out_ready;
        hold  = {pix_data, pix_x, pix_y, frame_last};
        if (done) n_done++;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    int   cyc;
    logic seen;

    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_ctrl", {busy, done, mem_rd_en, pix_valid, frame_last}, 5'b0);
    check("rst_data", {mem_addr, pix_data, pix_x, pix_y}, 38'b0);
    rst_n = 1'b1;
    wait_cycle();

    // Frame 1: full throughput, stray starts mid-frame and during done.
    seed  = 8'h00;
    mon_k = 0;
    start = 1'b1;
    wait_cycle();
    start = 1'b0;
    check("e0_ctrl", {busy, mem_rd_en, pix_valid}, 3'b110);
    check("e0_addr", mem_addr, 0);
    wait_cycle();
    check("e1_valid", pix_valid, 0);
    check("e1_addr", mem_addr, 1);
    wait_cycle();
    check("e2_pixel", {pix_valid, pix_data, pix_x, pix_y}, {1'b1, 8'h00, 10'd0, 10'd0});
    cyc  = 2;
    seen = 1'b0;
    while (cyc < 3000 && !seen) begin
      wait_cycle();
      cyc++;
      start = (cyc == 100);
      seen  = done;
    end
    check("f1_done_seen", seen, 1);
    check("f1_done_cycle", cyc, EXP_FRAME);
    check("f1_count", mon_k, N);
    check("f1_busy_at_done", busy, 0);
    start = 1'b1;
    wait_cycle();
    start = 1'b0;
    check("done_pulse_width", done, 0);
    check("start_in_done_ignored", {busy, mem_rd_en}, 2'b00);
    check("coord_wrap", {pix_x, pix_y}, 20'd0);
    repeat (3) wait_cycle();
    check("still_idle", {busy, mem_rd_en, pix_valid}, 3'b000);
    check("f1_one_done", n_done, 1);

    // Frame 2: initial stall, no-bubble release, then random backpressure.
    seed      = 8'h5A;
    mon_k     = 0;
    out_ready = 1'b0;
    start     = 1'b1;
    wait_cycle();
    start = 1'b0;
    repeat (10) wait_cycle();
    check("stall_p0", {pix_valid, pix_data}, {1'b1, 8'h5A});
    out_ready = 1'b1;
    wait_cycle();
    check("release_p1", {pix_valid, pix_data}, {1'b1, 8'h01 ^ 8'h5A});
    wait_cycle();
    check("release_p2", {pix_valid, pix_data}, {1'b1, 8'h02 ^ 8'h5A});
    wait_cycle();
    check("release_p3", {pix_valid, pix_data}, {1'b1, 8'h03 ^ 8'h5A});
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 8000 && !seen) begin
      out_ready = 1'($urandom_range(0, 1));
      wait_cycle();
      cyc++;
      seen = done;
    end
    out_ready = 1'b1;
    check("f2_done_seen", seen, 1);
    check("f2_count", mon_k, N);
    wait_cycle();
    check("f2_two_done", n_done, 2);

    // Frame 3: asynchronous reset at pixel 300 with a read outstanding.
    seed  = 8'hC3;
    mon_k = 0;
    start = 1'b1;
    wait_cycle();
    start = 1'b0;
    cyc   = 0;
    while (cyc < 2000 && mon_k < 300) begin
      wait_cycle();
      cyc++;
    end
    check("reached_300", mon_k >= 300, 1);
    check("read_outstanding", mem_rd_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {busy, done, mem_rd_en, pix_valid, frame_last}, 5'b0);
    check("midrst_data", {mem_addr, pix_data, pix_x, pix_y}, 38'b0);
    repeat (2) wait_cycle();
    rst_n = 1'b1;
    repeat (3) wait_cycle();
    check("post_rst_quiet", {busy, pix_valid, mem_rd_en}, 3'b000);

    seed  = 8'h3C;
    mon_k = 0;
    start = 1'b1;
    wait_cycle();
    start = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    while (cyc < 3000 && !seen) begin
      wait_cycle();
      cyc++;
      seen = done;
    end
    check("f4_done_seen", seen, 1);
    check("f4_done_cycle", cyc, EXP_FRAME);
    check("f4_count", mon_k, N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
